// File: rtl/la_pkg.sv
// Shared types and sizing for the logic-analyser capture path.
// State encoding, width defaults and the buffer depth helper.
package la_pkg;

  localparam int LA_DATA_WIDTH = 8;
  localparam int LA_ADDR_WIDTH = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_FILL,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } la_state_e;

  function automatic int unsigned la_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/trigger_match.sv
// Level/edge trigger matcher; owns the previous-sample register.
// In: cfg mask/value/edge, sample, clear/update. Out: hit_o (comb).
module trigger_match
  import la_pkg::*;
#(
  parameter int DATA_WIDTH = LA_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  update_i,
  input  logic [DATA_WIDTH-1:0] mask_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic [DATA_WIDTH-1:0] edge_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic                  hit_o
);

  logic [DATA_WIDTH-1:0] prev_q;
  logic                  prev_valid_q;
  logic [DATA_WIDTH-1:0] lvl_ok;
  logic [DATA_WIDTH-1:0] edg_ok;
  logic [DATA_WIDTH-1:0] bit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (clear_i) begin
      prev_valid_q <= 1'b0;
    end else if (update_i) begin
      prev_q       <= sample_i;
      prev_valid_q <= 1'b1;
    end
  end

  always_comb begin
    lvl_ok = ~(sample_i ^ value_i);
    // an edge bit needs a real previous sample and a change
    edg_ok = (prev_q ^ sample_i) & lvl_ok
           & {DATA_WIDTH{prev_valid_q}};
    bit_ok = ~mask_i
           | (edge_i & edg_ok)
           | (~edge_i & lvl_ok);
    hit_o  = &bit_ok;
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: ring writes, trigger, pre/post split.
// In: arm/abort, sample stream, trigger cfg. Out: status, write port.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int DATA_WIDTH = LA_DATA_WIDTH,
  parameter int ADDR_WIDTH = LA_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [DATA_WIDTH-1:0] trig_edge,
  input  logic [ADDR_WIDTH-1:0] pre_depth,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int unsigned DEPTH = la_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  la_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [DATA_WIDTH-1:0] edge_q, edge_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic                  triggered_q, triggered_d;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic                  busy_w;
  logic                  accept;
  logic                  arm_ok;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] cnt_inc;

  assign busy_w = (state_q == ST_PRE_FILL)
               || (state_q == ST_ARMED)
               || (state_q == ST_POST);
  // an abort-cycle sample is dropped
  assign accept  = sample_valid && busy_w && !abort;
  assign arm_ok  = arm && !abort
                && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cnt_inc = cnt_q + ONE;

  trigger_match #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_match (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (arm_ok),
    .update_i(accept),
    .mask_i  (mask_q),
    .value_i (value_q),
    .edge_i  (edge_q),
    .sample_i(sample_data),
    .hit_o   (hit)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    mask_d       = mask_q;
    value_d      = value_q;
    edge_d       = edge_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    triggered_d  = triggered_q;
    if (abort) begin
      state_d     = ST_IDLE;
      triggered_d = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            pre_d       = pre_depth;
            mask_d      = trig_mask;
            value_d     = trig_value;
            edge_d      = trig_edge;
            wr_ptr_d    = '0;
            cnt_d       = '0;
            triggered_d = 1'b0;
            state_d     = (pre_depth == '0) ? ST_ARMED
                                            : ST_PRE_FILL;
          end
        end
        ST_PRE_FILL: begin
          if (sample_valid) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pre_q) begin
              cnt_d   = '0;
              state_d = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (sample_valid && hit) begin
            trig_addr_d  = wr_ptr_q;
            start_addr_d = wr_ptr_q - pre_q;
            triggered_d  = 1'b1;
            cnt_d        = LAST_IDX - pre_q;
            state_d      = (pre_q == LAST_IDX) ? ST_DONE
                                               : ST_POST;
          end
        end
        ST_POST: begin
          if (sample_valid) begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (accept) wr_ptr_d = wr_ptr_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      edge_q       <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      triggered_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
      edge_q       <= edge_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      triggered_q  <= triggered_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= wr_ptr_q;
        wr_data_q <= sample_data;
      end
    end
  end

  assign busy       = busy_w;
  assign done       = (state_q == ST_DONE);
  assign triggered  = triggered_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Capture controller directly upstream of the dual-port sample buffer.
- Accepts the live sample stream and writes it circularly into the buffer through a registered write port (wr_en/wr_addr/wr_data).
- Evaluates a mask/value/edge trigger and stops after a programmable pre/post-trigger split.
- Reports the trigger address and the oldest-sample address, so the read side can unroll the ring.

Parameters:
- DATA_WIDTH, 8: sample width in bits.
- ADDR_WIDTH, 11: buffer address width; DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  in  1  single system clock; also drives the buffer write clock.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  1-cycle pulse; starts a capture from IDLE or DONE.
- abort  in  1  1-cycle pulse; returns to IDLE from any state.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  DATA_WIDTH  incoming sample.
- trig_mask  in  DATA_WIDTH  bits that take part in the trigger.
- trig_value  in  DATA_WIDTH  required level, or edge polarity (1 = rising).
- trig_edge  in  DATA_WIDTH  1 = bit is edge-sensitive, 0 = level-sensitive.
- pre_depth  in  ADDR_WIDTH  number of samples kept before the trigger sample.
- busy  out  1  high in PRE_FILL, ARMED and POST.
- triggered  out  1  trigger seen in this capture.
- done  out  1  capture complete; buffer holds DEPTH valid samples.
- trig_addr  out  ADDR_WIDTH  buffer address of the trigger sample.
- start_addr  out  ADDR_WIDTH  address of the oldest sample: (trig_addr - pre_depth) mod DEPTH.
- wr_en  out  1  buffer write enable.
- wr_addr  out  ADDR_WIDTH  buffer write address.
- wr_data  out  DATA_WIDTH  buffer write data.

Behaviour:
- Reset: state = IDLE. All outputs are 0. wr_ptr = 0, counters = 0, prev_valid = 0.
- Config latch: trig_mask, trig_value, trig_edge and pre_depth are captured on the accepted arm. Input changes during a capture have no effect.
- Write path:
  - An accepted sample is one where sample_valid = 1 in PRE_FILL, ARMED or POST.
  - For each accepted sample, in the next cycle: wr_en = 1, wr_addr = wr_ptr, wr_data = sample. Latency is exactly 1 cycle.
  - wr_ptr then increments mod DEPTH; natural wrap from DEPTH-1 to 0.
  - In all other cycles wr_en = 0.
- Trigger match (combinational on the current accepted sample):
  - Level bits (mask & ~edge): sample bit == value bit.
  - Edge bits (mask & edge): prev_valid = 1, prev bit != sample bit, and sample bit == value bit.
  - trig_mask = 0 matches the first eligible sample.
  - prev register: updated on every accepted sample; prev_valid is cleared on arm.
- FSM:
  - IDLE: on arm, wr_ptr = 0, clear triggered/done/prev_valid. Go to PRE_FILL, or to ARMED if pre_depth = 0.
  - PRE_FILL: trigger ignored. Count accepted samples; after pre_depth of them, go to ARMED.
  - ARMED: keep writing circularly. On the first matching accepted sample:
    - trig_addr = wr_ptr, triggered = 1, start_addr = wr_ptr - pre_depth (mod DEPTH);
    - post_cnt = DEPTH-1-pre_depth;
    - go to POST, or to DONE if post_cnt = 0.
  - POST: each accepted sample decrements post_cnt. The sample that takes post_cnt from 1 to 0 is written, then go to DONE.
  - DONE: done = 1, no writes, trig_addr/start_addr held. arm starts a new capture and clears done in the same transition.
- Total writes from trigger onward: pre_depth before the trigger sample plus DEPTH-pre_depth from the trigger sample on.
- Boundaries:
  - arm while busy is ignored.
  - abort has priority over arm and over every other event in the same cycle. Next state is IDLE with busy/triggered/done = 0.
  - A write already registered from an abort-cycle sample still completes. An abort-cycle sample is not accepted.
  - sample_valid = 0 stalls every counter.
  - A trigger match on the last PRE_FILL sample is not honoured; the first eligible sample is the one after it.
  - Asynchronous reset mid-capture forces reset values immediately.

Decomposition:
- Shared package `la_pkg`:
  - state encoding enum (IDLE, PRE_FILL, ARMED, POST, DONE);
  - DATA_WIDTH/ADDR_WIDTH defaults;
  - DEPTH constant function.
- One natural sub-module, `trigger_match`: combinational level/edge matcher (mask, value, edge, prev, prev_valid, sample → hit) holding the prev register. It is reusable by a future multi-stage trigger.

Test Plan (bench uses ADDR_WIDTH = 4, DEPTH = 16):
1. Basic capture: pre_depth = 4, mask = FF, value = 20, edge = 00, ramp 00,01,… valid every cycle → 4 pre-fill writes; trigger on sample 20 at wr_addr 0; trig_addr = 0, start_addr = 12; 11 post writes (addr 1..11); done one cycle after data 2B is accepted; 44 writes total.
2. Edge trigger: mask = 01, edge = 01, value = 0, pre_depth = 0, data 01,01,00 → trigger on the third sample (falling edge), trig_addr = 2. The first sample never edge-triggers (prev_valid = 0).
3. Boundaries: pre_depth = 15, mask = 00 → trigger on the 16th sample, post_cnt = 0; done right after the trigger write; start_addr = (trig_addr + 1) mod 16.
4. Stall: toggle sample_valid 1/0 during scenario 1 → identical wr_addr/wr_data sequence and trig_addr; no wr_en in cycles following valid = 0.
5. Abort and arm: abort in POST → busy = done = 0 next cycle, no further wr_en. arm while busy is ignored; arm in DONE restarts with wr_ptr = 0.
6. Reset: assert rst_n = 0 mid-POST → all outputs 0 asynchronously; after release, state IDLE and no writes until arm.
